// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches and buffers the
// returned words with their PCs for decode. Redirects squash every fetch still in flight.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  typedef enum logic [1:0] {StReset, StRun, StDrain} state_e;

  state_e          r_state;
  logic [31:0]     r_fetch_pc;
  logic            r_req_valid;
  logic [CntW-1:0] r_q_cnt;
  logic [CntW-1:0] r_live_cnt;
  logic [CntW-1:0] r_stale_cnt;
  logic [PtrW-1:0] r_q_wr;
  logic [PtrW-1:0] r_q_rd;
  logic [PtrW-1:0] r_tag_wr;
  logic [PtrW-1:0] r_tag_rd;
  logic [31:0]     r_q_pc   [QDEPTH];
  logic [31:0]     r_q_code [QDEPTH];
  logic [31:0]     r_tag_pc [QDEPTH];

  logic            w_req_fire;
  logic            w_pop;
  logic            w_rsp_live;
  logic            w_tag_push;
  logic [CntW-1:0] w_q_cnt;
  logic [CntW-1:0] w_live_cnt;
  logic [CntW-1:0] w_stale_cnt;
  logic [CntW:0]   w_credit_sum;
  logic            w_req_valid;

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign inst_valid     = (r_q_cnt != '0);
  assign inst_code      = inst_valid ? r_q_code[r_q_rd] : Nop;
  assign inst_pc        = inst_valid ? r_q_pc[r_q_rd] : RESET_PC;

  always_comb begin
    w_req_fire = r_req_valid & imem_req_ready;
    w_pop      = inst_valid & inst_ready;
    // Responses are only kept once every squashed request has come back.
    w_rsp_live = imem_rsp_valid & ~redirect_valid & (r_stale_cnt == '0);
    w_tag_push = w_req_fire & ~redirect_valid;

    if (redirect_valid) begin
      w_q_cnt     = '0;
      w_live_cnt  = '0;
      w_stale_cnt = r_stale_cnt + r_live_cnt + CntW'(w_req_fire) - CntW'(imem_rsp_valid);
    end else begin
      w_q_cnt     = r_q_cnt + CntW'(w_rsp_live) - CntW'(w_pop);
      w_live_cnt  = r_live_cnt + CntW'(w_req_fire) - CntW'(w_rsp_live);
      w_stale_cnt = r_stale_cnt - CntW'(imem_rsp_valid && (r_stale_cnt != '0));
    end

    // Request valid is registered, so it is computed from next-cycle occupancy.
    w_credit_sum = {1'b0, w_q_cnt} + {1'b0, w_live_cnt} + {1'b0, w_stale_cnt};
    w_req_valid  = (w_credit_sum < (CntW + 1)'(QDEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StReset;
      r_fetch_pc  <= RESET_PC;
      r_req_valid <= 1'b0;
      r_q_cnt     <= '0;
      r_live_cnt  <= '0;
      r_stale_cnt <= '0;
      r_q_wr      <= '0;
      r_q_rd      <= '0;
      r_tag_wr    <= '0;
      r_tag_rd    <= '0;
    end else begin
      case (r_state)
        StReset: r_state <= StRun;
        default: r_state <= (w_stale_cnt != '0) ? StDrain : StRun;
      endcase

      r_req_valid <= w_req_valid;
      r_q_cnt     <= w_q_cnt;
      r_live_cnt  <= w_live_cnt;
      r_stale_cnt <= w_stale_cnt;

      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end

      if (redirect_valid) begin
        r_q_wr   <= '0;
        r_q_rd   <= '0;
        r_tag_wr <= '0;
        r_tag_rd <= '0;
      end else begin
        if (w_rsp_live) begin
          r_q_wr   <= r_q_wr + 1'b1;
          r_tag_rd <= r_tag_rd + 1'b1;
        end
        if (w_pop) begin
          r_q_rd <= r_q_rd + 1'b1;
        end
        if (w_tag_push) begin
          r_tag_wr <= r_tag_wr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rsp_live) begin
      r_q_pc[r_q_wr]   <= r_tag_pc[r_tag_rd];
      r_q_code[r_q_wr] <= imem_rsp_data;
    end
    if (w_tag_push) begin
      r_tag_pc[r_tag_wr] <= r_fetch_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: reset/stall vector table, redirect and wrap sequences, async reset,
// and a randomized run scored against an in-order memory and expected-stream model.
module tb_inst_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned QDepth  = 4;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;

  inst_fetch #(
    .RESET_PC (ResetPc),
    .QDEPTH   (QDepth)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_code      (inst_code),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } mreq_t;

  typedef struct {
    bit          ir;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] pc;
  } vec_t;

  mreq_t       memq[$];
  logic [31:0] bufq[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_req;
  bit          running;
  int unsigned cyc;
  int unsigned last_due;
  int unsigned lat_min;
  int unsigned lat_max;
  int          n_vec;
  int          n_err;
  int          n_pops;

  bit          ctl_req_ready;
  bit          ctl_inst_ready;
  bit          ctl_redirect;
  logic [31:0] ctl_target;

  vec_t tbl[21];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ctl(input bit rr, input bit ir, input bit rd, input logic [31:0] tgt);
    ctl_req_ready  = rr;
    ctl_inst_ready = ir;
    ctl_redirect   = rd;
    ctl_target     = tgt;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step();
    bit          acc;
    bit          rsp;
    bit          pop;
    mreq_t       m;
    int unsigned d;
    rsp            = (memq.size() != 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(memq[0].addr) : 32'h0;
    imem_req_ready = ctl_req_ready;
    inst_ready     = ctl_inst_ready;
    redirect_valid = ctl_redirect;
    redirect_pc    = ctl_target;
    #1;
    check("req_valid", imem_req_valid,
          running && ((bufq.size() + memq.size()) < QDepth));
    check("inst_valid", inst_valid, bufq.size() != 0);
    if (bufq.size() == 0) check("idle_nop", inst_code, Nop);
    acc = imem_req_valid & imem_req_ready;
    pop = inst_valid & inst_ready;
    if (acc) begin
      check("req_addr", imem_req_addr, exp_req);
      acc_log.push_back(imem_req_addr);
      exp_req += 32'd4;
    end
    if (pop && !ctl_redirect && bufq.size() != 0) begin
      check("inst_pc", inst_pc, bufq[0]);
      check("inst_code", inst_code, mem_word(bufq[0]));
      pop_log.push_back(inst_pc);
      n_pops++;
      void'(bufq.pop_front());
    end
    if (rsp) begin
      m = memq.pop_front();
      if (!m.stale && !ctl_redirect) bufq.push_back(m.addr);
    end
    if (acc) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (memq.size() != 0 && d <= last_due) d = last_due + 1;
      last_due = d;
      memq.push_back('{addr: imem_req_addr, due: d, stale: 1'b0});
    end
    if (ctl_redirect) begin
      bufq.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      exp_req = ctl_target & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    if (rst_n) running = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    memq.delete();
    bufq.delete();
    acc_log.delete();
    pop_log.delete();
    exp_req  = ResetPc;
    running  = 1'b0;
    last_due = 0;
    set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_row(input int k, input bit ir, input bit rv, input logic [31:0] addr,
                         input bit iv, input logic [31:0] pc);
    tbl[k] = '{ir: ir, rv: rv, addr: addr, iv: iv, pc: pc};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    n_pops  = 0;
    cyc     = 0;
    lat_min = 1;
    lat_max = 1;

    // Reset, decode stalled for 10 cycles, then 1/cycle streaming with 1-cycle memory.
    set_row( 0, 0, 0, 32'h00, 0, 32'h00);
    set_row( 1, 0, 1, 32'h00, 0, 32'h00);
    set_row( 2, 0, 1, 32'h04, 0, 32'h00);
    set_row( 3, 0, 1, 32'h08, 1, 32'h00);
    set_row( 4, 0, 1, 32'h0C, 1, 32'h00);
    for (int k = 5; k <= 12; k++) set_row(k, 0, 0, 32'h10, 1, 32'h00);
    set_row(13, 1, 0, 32'h10, 1, 32'h00);
    for (int k = 14; k <= 20; k++) set_row(k, 1, 1, 32'h10 + 4 * (k - 14), 1, 4 * (k - 13));

    rst_n = 1'b0;
    apply_reset();
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_req_addr", imem_req_addr, ResetPc);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_code", inst_code, Nop);
    check("rst_inst_pc", inst_pc, ResetPc);
    for (int k = 0; k < 21; k++) begin
      check("tbl_req_valid", imem_req_valid, tbl[k].rv);
      if (tbl[k].rv) check("tbl_req_addr", imem_req_addr, tbl[k].addr);
      check("tbl_inst_valid", inst_valid, tbl[k].iv);
      if (tbl[k].iv) begin
        check("tbl_inst_pc", inst_pc, tbl[k].pc);
        check("tbl_inst_code", inst_code, mem_word(tbl[k].pc));
      end else begin
        check("tbl_inst_nop", inst_code, Nop);
      end
      set_ctl(1'b1, tbl[k].ir, 1'b0, 32'h0);
      step();
    end
    check("tbl_four_before_stall", acc_log[4], 32'h10);

    // 3-cycle memory, two requests in flight, redirect to 0x100.
    lat_min = 3;
    lat_max = 3;
    apply_reset();
    step();
    step();
    step();
    set_ctl(1'b0, 1'b1, 1'b1, 32'h100);
    step();
    set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_req_valid", imem_req_valid, 1'b1);
    check("t3_req_addr", imem_req_addr, 32'h100);
    pop_log.delete();
    for (int i = 0; i < 20 && pop_log.size() < 3; i++) step();
    check("t3_delivered", pop_log.size() >= 3, 1'b1);
    if (pop_log.size() >= 3) begin
      check("t3_first_pc", pop_log[0], 32'h100);
      check("t3_third_pc", pop_log[2], 32'h108);
    end

    // Redirect to 0x203 while a request is accepted and a response returns.
    lat_min = 1;
    lat_max = 1;
    apply_reset();
    repeat (5) step();
    check("t4_setup_req", imem_req_valid, 1'b1);
    set_ctl(1'b1, 1'b1, 1'b1, 32'h203);
    step();
    set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
    check("t4_req_addr", imem_req_addr, 32'h200);
    pop_log.delete();
    for (int i = 0; i < 10 && pop_log.size() == 0; i++) step();
    check("t4_delivered", pop_log.size() != 0, 1'b1);
    if (pop_log.size() != 0) check("t4_first_pc", pop_log[0], 32'h200);

    // Address wrap at the top of memory.
    set_ctl(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    step();
    set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
    acc_log.delete();
    pop_log.delete();
    repeat (8) step();
    check("wrap_count", acc_log.size() >= 3, 1'b1);
    if (acc_log.size() >= 3) begin
      check("wrap_a0", acc_log[0], 32'hFFFF_FFF8);
      check("wrap_a1", acc_log[1], 32'hFFFF_FFFC);
      check("wrap_a2", acc_log[2], 32'h0000_0000);
    end
    if (pop_log.size() >= 3) check("wrap_pop2", pop_log[2], 32'h0000_0000);

    // Asynchronous reset in the middle of a burst.
    repeat (4) step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req_valid", imem_req_valid, 1'b0);
    check("arst_req_addr", imem_req_addr, ResetPc);
    check("arst_inst_valid", inst_valid, 1'b0);
    check("arst_inst_code", inst_code, Nop);
    check("arst_inst_pc", inst_pc, ResetPc);
    apply_reset();
    repeat (4) step();
    check("arst_restart", acc_log.size() != 0, 1'b1);
    if (acc_log.size() != 0) check("arst_first_addr", acc_log[0], ResetPc);

    // Randomized traffic with variable latency, backpressure and redirects.
    lat_min = 1;
    lat_max = 4;
    apply_reset();
    n_pops = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                        : $urandom();
      set_ctl($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 70,
              $urandom_range(99, 0) < 3, tgt);
      step();
      if (pop_log.size() > 64) pop_log.delete();
      if (acc_log.size() > 64) acc_log.delete();
    end
    check("rand_progress", n_pops > 300, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
